// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Byte-merge function used by the read-modify-write path.
package dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  localparam int         WORD_W  = 32;
  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] m;
    m = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) m[8*k +: 8] = new_w[8*k +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Round-robin grant picker: first set request at or after ptr.
// Pure combinational; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory.
// Partial-strobe stores run as a two-cycle read-modify-write.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int N_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*32-1:0]         req_wdata,
  input  logic [N_REQ*4-1:0]          req_be,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [31:0]                 rsp_rdata,
  output logic                        mem_wr_en,
  output logic [ADDR_WIDTH-1:0]       mem_address,
  output logic [31:0]                 mem_wr_data,
  input  logic [31:0]                 mem_rd_data
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t                  state;
  logic [IW-1:0]           ptr;
  logic [IW-1:0]           lat_idx;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_data;

  logic [N_REQ-1:0]        req_live;
  logic [N_REQ-1:0]        gnt;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           next_ptr;
  logic                    go;

  logic                    g_we;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [31:0]             g_wdata;
  logic [3:0]              g_be;

  logic                    is_ld;
  logic                    is_pass;
  logic                    is_part;

  // No new grants while the RMW write cycle owns the memory port.
  assign req_live = (state == IDLE) ? req_valid : '0;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req (req_live),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (go)
  );

  assign req_ready = gnt;

  always_comb begin
    g_we    = req_we[idx];
    g_addr  = req_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
    g_wdata = req_wdata[int'(idx)*32 +: 32];
    g_be    = req_be[int'(idx)*4 +: 4];
  end

  always_comb begin
    is_ld   = go && !g_we;
    is_pass = go && g_we &&
              (g_be == BE_FULL || g_be == BE_NONE);
    is_part = go && g_we &&
              !(g_be == BE_FULL || g_be == BE_NONE);
  end

  assign next_ptr = (idx == IW'(N_REQ - 1)) ?
                    '0 : idx + 1'b1;

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_address = '0;
    mem_wr_data = '0;
    unique case (1'b1)
      (state == RMW): begin
        mem_wr_en   = 1'b1;
        mem_address = lat_addr;
        mem_wr_data = lat_data;
      end
      go: begin
        mem_address = g_addr;
        if (g_we && g_be == BE_FULL) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = g_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      lat_idx   <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (go) ptr <= next_ptr;
          unique case (1'b1)
            is_ld: begin
              rsp_rdata <= mem_rd_data;
              rsp_valid <= gnt;
            end
            is_pass: begin
              rsp_rdata <= '0;
              rsp_valid <= gnt;
            end
            is_part: begin
              lat_addr <= g_addr;
              lat_idx  <= idx;
              lat_data <= be_merge(mem_rd_data,
                                   g_wdata, g_be);
              state    <= RMW;
            end
            default: ;
          endcase
        end
        RMW: begin
          state              <= IDLE;
          rsp_rdata          <= '0;
          rsp_valid[lat_idx] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory.
// Expected values are hand-computed constants.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*32-1:0] req_wdata;
  logic [NR*4-1:0] req_be;
  logic [NR-1:0]   rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_address;
  logic [31:0]     mem_wr_data;
  logic [31:0]     mem_rd_data;

  logic [31:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_wr_en) mem[mem_address] <= mem_wr_data;

  assign mem_rd_data = mem[mem_address];

  dmem_arbiter #(
    .ADDR_WIDTH (AW),
    .N_REQ      (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_address (mem_address),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r,
                         input logic we,
                         input logic [AW-1:0] a,
                         input logic [31:0] d,
                         input logic [3:0] be);
    req_valid[r]          = 1'b1;
    req_we[r]             = we;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*32 +: 32] = d;
    req_be[r*4 +: 4]      = be;
  endtask

  task automatic clr_req(input int r);
    req_valid[r] = 1'b0;
    req_we[r]    = 1'b0;
  endtask

  task automatic store_full(input int r,
                            input logic [AW-1:0] a,
                            input logic [31:0] d);
    set_req(r, 1'b1, a, d, 4'hF);
    tick();
    clr_req(r);
  endtask

  initial begin
    logic [NR-1:0] exp_g;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    repeat (2) tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Contention: both requesters load every cycle.
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b0, AW'(20 + i), 32'h0, 4'h0);
      set_req(1, 1'b0, AW'(40 + i), 32'h0, 4'h0);
      #1;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr_ready_%0d", i),
          32'(req_ready), 32'(exp_g));
      chk($sformatf("rr_addr_%0d", i),
          32'(mem_address),
          (i % 2 == 0) ? 32'(20 + i) : 32'(40 + i));
      tick();
      chk($sformatf("rr_rsp_%0d", i),
          32'(rsp_valid), 32'(exp_g));
    end
    clr_req(0);
    clr_req(1);
    tick();

    store_full(0, 10'd3, 32'h0);
    store_full(1, 10'd7, 32'h11223344);
    store_full(1, 10'd9, 32'h55);
    tick();

    // Full store then load, requester 0.
    set_req(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    #1;
    chk("fs_ready", 32'(req_ready), 32'h1);
    chk("fs_wr_en", 32'(mem_wr_en), 32'h1);
    chk("fs_addr", 32'(mem_address), 32'd5);
    chk("fs_wdata", mem_wr_data, 32'hDEADBEEF);
    tick();
    chk("fs_rsp", 32'(rsp_valid), 32'h1);
    chk("fs_rdata", rsp_rdata, 32'h0);
    set_req(0, 1'b0, 10'd5, 32'h0, 4'h0);
    #1;
    chk("ld_ready", 32'(req_ready), 32'h1);
    chk("ld_wr_en", 32'(mem_wr_en), 32'h0);
    tick();
    clr_req(0);
    chk("ld_rsp", 32'(rsp_valid), 32'h1);
    chk("ld_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();
    chk("idle_wr_en", 32'(mem_wr_en), 32'h0);
    chk("idle_addr", 32'(mem_address), 32'h0);
    chk("idle_rsp", 32'(rsp_valid), 32'h0);

    // Partial store, then requester 1 reads it back.
    set_req(0, 1'b1, 10'd7, 32'hAABBCCDD, 4'b0101);
    #1;
    chk("ps_ready", 32'(req_ready), 32'h1);
    chk("ps_rd_wr_en", 32'(mem_wr_en), 32'h0);
    chk("ps_rd_addr", 32'(mem_address), 32'd7);
    tick();
    clr_req(0);
    set_req(1, 1'b0, 10'd7, 32'h0, 4'h0);
    #1;
    chk("rmw_ready", 32'(req_ready), 32'h0);
    chk("rmw_wr_en", 32'(mem_wr_en), 32'h1);
    chk("rmw_addr", 32'(mem_address), 32'd7);
    chk("rmw_wdata", mem_wr_data, 32'h11BB33DD);
    chk("rmw_rsp", 32'(rsp_valid), 32'h0);
    tick();
    chk("ps_rsp", 32'(rsp_valid), 32'h1);
    chk("ps_ld_ready", 32'(req_ready), 32'h2);
    tick();
    clr_req(1);
    chk("ps_ld_rsp", 32'(rsp_valid), 32'h2);
    chk("ps_ld_rdata", rsp_rdata, 32'h11BB33DD);
    tick();

    // Reset lands in the RMW cycle.
    set_req(0, 1'b1, 10'd3, 32'hFFFFFFFF, 4'b0011);
    tick();
    clr_req(0);
    #1;
    chk("rr_rmw_wr_en", 32'(mem_wr_en), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_wr_en", 32'(mem_wr_en), 32'h0);
    chk("ar_rsp", 32'(rsp_valid), 32'h0);
    tick();
    chk("ar_word3", mem[3], 32'h0);
    rst_n = 1'b1;
    tick();
    chk("ar_rsp_after", 32'(rsp_valid), 32'h0);
    chk("ar_word3_after", mem[3], 32'h0);

    // Empty-strobe store must not touch memory.
    set_req(1, 1'b1, 10'd9, 32'hFFFFFFFF, 4'h0);
    #1;
    chk("be0_ready", 32'(req_ready), 32'h2);
    chk("be0_wr_en", 32'(mem_wr_en), 32'h0);
    tick();
    clr_req(1);
    chk("be0_rsp", 32'(rsp_valid), 32'h2);
    chk("be0_wr_en2", 32'(mem_wr_en), 32'h0);
    chk("be0_word9", mem[9], 32'h55);
    set_req(0, 1'b0, 10'd9, 32'h0, 4'h0);
    tick();
    clr_req(0);
    chk("be0_ld_rsp", 32'(rsp_valid), 32'h1);
    chk("be0_ld_rdata", rsp_rdata, 32'h55);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
